apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Single-outstanding APB master that turns a simple valid/ready command interface into APB setup/access transfers for the register-file slaves in this design. Sits directly upstream of the APB slave interface blocks and is driven by the host/bus-controller logic. Returns read data, slave error and a watchdog timeout through a buffered response handshake, so an unmapped address that never returns `APB_READY` cannot hang the host.

## Interface
- `DATAWIDTH`, default 32: APB data and address width; only 32 and 64 are legal.
- `STRB_WIDTH`, default derived: 4 when `DATAWIDTH`<=32, else 8.
- `ADDR_LSB`, default derived: `DATAWIDTH/32+1`; this many address LSBs are forced to zero.
- `TIMEOUT`, default 16: maximum ACCESS cycles without `APB_READY` before abort; legal range 2..255.
- `PROT`, default 3'b000: constant driven on `APB_PROT`.

Ports:
- `APB_CLK` in 1: the only clock.
- `APB_RESETn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in DATAWIDTH: byte address.
- `cmd_wdata` in DATAWIDTH: write data.
- `cmd_strb` in STRB_WIDTH: write byte strobes.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out DATAWIDTH: read data; 0 for writes, errors and timeouts.
- `rsp_err` out 1: `APB_SLVERR` seen, or timeout.
- `rsp_timeout` out 1: the transfer was aborted by the watchdog.
- `APB_SEL`, `APB_ENABLE`, `APB_WRITE` out 1: APB control.
- `APB_ADDR`, `APB_WDATA` out DATAWIDTH: APB address and write data.
- `APB_STRB` out STRB_WIDTH: APB byte strobes.
- `APB_PROT` out 3: APB protection.
- `APB_RDATA` in DATAWIDTH, `APB_READY` in 1, `APB_SLVERR` in 1: slave return.

## Operation
- All outputs are registered. Reset value of every output is 0, except `APB_PROT` = `PROT` and `cmd_ready` = 1.
- Reset clears the state to IDLE and the timeout counter to 0 at once. Asserting reset mid-transfer drops `APB_SEL`/`APB_ENABLE` immediately and produces no response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch the command and go to SETUP. Latched fields:
  - `APB_ADDR` = `cmd_addr` with `[ADDR_LSB-1:0]` cleared.
  - `APB_WRITE`, `APB_WDATA` from the command.
  - `APB_STRB` = `cmd_strb` for writes, 0 for reads.
- SETUP: `APB_SEL`=1, `APB_ENABLE`=0 for exactly one cycle, then go to ACCESS.
- ACCESS: `APB_SEL`=1, `APB_ENABLE`=1. The address, data and control outputs hold stable for the whole transfer.
  - The counter increments every ACCESS cycle in which `APB_READY`=0.
  - `APB_READY`=1: capture `rsp_rdata` (`APB_RDATA` if read, else 0) and `rsp_err`=`APB_SLVERR`, set `rsp_timeout`=0, go to RESP.
  - Counter reaches `TIMEOUT`-1 with `APB_READY` still 0: go to RESP with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - `APB_READY` arriving on the same cycle as the timeout threshold wins; the transfer completes normally.
- RESP: `APB_SEL`=`APB_ENABLE`=0, `rsp_valid`=1, response fields held stable. On `rsp_ready`, return to IDLE and clear the counter.
- Only one transfer is outstanding; `cmd_ready` is 0 in SETUP, ACCESS and RESP.
- `APB_READY` and `APB_SLVERR` are ignored outside ACCESS.

## Timing
- Command handshake at edge N gives:
  - `APB_SEL`=1 from N+1.
  - `APB_ENABLE`=1 from N+2.
  - `cmd_ready`=0 from N+1.
- `APB_READY` sampled high at edge K gives `APB_SEL`=`APB_ENABLE`=0 and `rsp_valid`=1 from K+1.
- `rsp_ready` sampled high at edge R gives `rsp_valid`=0 and `cmd_ready`=1 from R+1. The next command is accepted at R+1 at the earliest.
- With a slave that answers `APB_READY` one cycle after seeing `APB_ENABLE`, a transfer occupies accept + SETUP + 2 ACCESS + RESP, i.e. 5 cycles minimum per command.
- Timeout abort: `rsp_valid` rises `TIMEOUT`+1 cycles after the handshake edge N (SETUP plus `TIMEOUT` ACCESS cycles).

## Test plan
- Write then read:
  - Stimulus: write addr 0x8, data 0xDEADBEEF, strb 0xF; then read addr 0x8, `DATAWIDTH`=32.
  - Required: write response `rsp_err`=0, `rsp_rdata`=0; read response `rsp_rdata`=0xDEADBEEF.
  - Required APB sequence: one SETUP cycle then ACCESS; `APB_STRB`=0 on the read.
- Unaligned address: `cmd_addr`=0x0B -> `APB_ADDR`=0x08.
- Timeout: slave never asserts `APB_READY`, `TIMEOUT`=16 -> ACCESS lasts exactly 16 cycles, then `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0 and `APB_SEL` drops.
- Slave error: read with `APB_SLVERR`=1 together with `APB_READY` -> `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0.
- Response backpressure: `rsp_ready` held low for 5 cycles with a second `cmd_valid` pending -> `rsp_valid` and the response fields stay stable, `cmd_ready`=0 throughout; the second command is accepted one cycle after `rsp_ready`.
- Reset mid-ACCESS: `APB_RESETn` pulled low while `APB_ENABLE`=1 -> all APB outputs 0 asynchronously, `rsp_valid`=0, `cmd_ready`=1 after release. A following read completes normally.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge_if
// Purpose  : Bundles the command/response handshake and the APB bus seen by
//            apb_master_bridge.
// Ports    : cmd_*   - host command channel (valid/ready)
//            rsp_*   - buffered response channel (valid/ready)
//            APB_*   - APB master-side bus signals
// Modports : master  - the bridge (drives cmd_ready, rsp_*, APB control)
//            slave   - the environment (host + APB slave)
// Revision : 1.0 - initial release
// ============================================================================
interface apb_master_bridge_if #(
    parameter int DATAWIDTH  = 32,
    parameter int STRB_WIDTH = (DATAWIDTH <= 32) ? 4 : 8
);
    // Command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [DATAWIDTH-1:0]  cmd_addr;
    logic [DATAWIDTH-1:0]  cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_strb;

    // Response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATAWIDTH-1:0]  rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // APB bus
    logic                  APB_SEL;
    logic                  APB_ENABLE;
    logic                  APB_WRITE;
    logic [DATAWIDTH-1:0]  APB_ADDR;
    logic [DATAWIDTH-1:0]  APB_WDATA;
    logic [STRB_WIDTH-1:0] APB_STRB;
    logic [2:0]            APB_PROT;
    logic [DATAWIDTH-1:0]  APB_RDATA;
    logic                  APB_READY;
    logic                  APB_SLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output APB_SEL, APB_ENABLE, APB_WRITE, APB_ADDR, APB_WDATA, APB_STRB, APB_PROT,
        input  APB_RDATA, APB_READY, APB_SLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  APB_SEL, APB_ENABLE, APB_WRITE, APB_ADDR, APB_WDATA, APB_STRB, APB_PROT,
        output APB_RDATA, APB_READY, APB_SLVERR
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Purpose  : Single-outstanding APB master. Converts a valid/ready command
//            into an APB SETUP/ACCESS transfer and returns read data, slave
//            error and a watchdog timeout through a buffered response.
// Ports    : APB_CLK    - clock
//            APB_RESETn - asynchronous active-low reset
//            bus        - apb_master_bridge_if.master (cmd_*, rsp_*, APB_*)
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter int         DATAWIDTH  = 32,
    parameter int         STRB_WIDTH = (DATAWIDTH <= 32) ? 4 : 8,
    parameter int         ADDR_LSB   = DATAWIDTH / 32 + 1,
    parameter int         TIMEOUT    = 16,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  wire logic           APB_CLK,
    input  wire logic           APB_RESETn,
    apb_master_bridge_if.master bus
);

    // Clears the sub-word address bits so every transfer is word aligned.
    localparam logic [DATAWIDTH-1:0] c_ADDR_MASK =
        {{(DATAWIDTH - ADDR_LSB){1'b1}}, {ADDR_LSB{1'b0}}};
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                state_q,     state_d;
    logic [7:0]            cnt_q,       cnt_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  sel_q,       sel_d;
    logic                  enable_q,    enable_d;
    logic                  write_q,     write_d;
    logic [DATAWIDTH-1:0]  addr_q,      addr_d;
    logic [DATAWIDTH-1:0]  wdata_q,     wdata_d;
    logic [STRB_WIDTH-1:0] strb_q,      strb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATAWIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic                  rsp_to_q,    rsp_to_d;
    logic [2:0]            prot_q;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        sel_d       = sel_q;
        enable_d    = enable_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d     = S_SETUP;
                    cmd_ready_d = 1'b0;
                    sel_d       = 1'b1;
                    write_d     = bus.cmd_write;
                    addr_d      = bus.cmd_addr & c_ADDR_MASK;
                    wdata_d     = bus.cmd_wdata;
                    strb_d      = bus.cmd_write ? bus.cmd_strb : '0;
                end
            end

            S_SETUP: begin
                state_d  = S_ACCESS;
                enable_d = 1'b1;
            end

            S_ACCESS: begin
                // READY is checked first so a completion on the threshold
                // cycle beats the watchdog.
                if (bus.APB_READY) begin
                    state_d     = S_RESP;
                    sel_d       = 1'b0;
                    enable_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (write_q || bus.APB_SLVERR) ? '0 : bus.APB_RDATA;
                    rsp_err_d   = bus.APB_SLVERR;
                    rsp_to_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == c_TIMEOUT_LAST) begin
                        state_d     = S_RESP;
                        sel_d       = 1'b0;
                        enable_d    = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        rsp_to_d    = 1'b1;
                    end
                end
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    cnt_d       = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge APB_CLK or negedge APB_RESETn) begin
        if (!APB_RESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            prot_q      <= PROT;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            sel_q       <= sel_d;
            enable_q    <= enable_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            prot_q      <= PROT;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_to_q;
    assign bus.APB_SEL     = sel_q;
    assign bus.APB_ENABLE  = enable_q;
    assign bus.APB_WRITE   = write_q;
    assign bus.APB_ADDR    = addr_q;
    assign bus.APB_WDATA   = wdata_q;
    assign bus.APB_STRB    = strb_q;
    assign bus.APB_PROT    = prot_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Purpose  : Self-checking bench for apb_master_bridge (DATAWIDTH=32,
//            TIMEOUT=16). Table of transfers plus hand-written sequences for
//            response backpressure and reset during ACCESS.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam logic [2:0] c_PROT = 3'b010;

    logic clk;
    logic rst_n;

    apb_master_bridge_if #(.DATAWIDTH(32)) bus ();

    apb_master_bridge #(
        .DATAWIDTH (32),
        .TIMEOUT   (16),
        .PROT      (c_PROT)
    ) dut (
        .APB_CLK    (clk),
        .APB_RESETn (rst_n),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          dly;      // ACCESS cycles before slave asserts READY
        logic        serr;
        int          bp;       // rsp_ready hold-off cycles
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
        int          e_acc;    // expected ACCESS cycle count
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Slave model configuration, set per transfer
    int   slv_delay;
    logic slv_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // APB slave: word memory of 16 entries, READY after slv_delay ACCESS cycles
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] mem [16];
        int          en_cnt;
        logic [3:0]  idx;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        en_cnt         = 0;
        bus.APB_READY  = 1'b0;
        bus.APB_SLVERR = 1'b0;
        bus.APB_RDATA  = '0;
        forever begin
            @(negedge clk);
            idx = bus.APB_ADDR[5:2];
            if (bus.APB_SEL === 1'b1 && bus.APB_ENABLE === 1'b1) begin
                if (en_cnt == slv_delay) begin
                    bus.APB_READY  = 1'b1;
                    bus.APB_SLVERR = slv_err;
                    bus.APB_RDATA  = bus.APB_WRITE ? 32'h0 : mem[idx];
                    if (bus.APB_WRITE && !slv_err) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.APB_STRB[b]) mem[idx][8*b +: 8] = bus.APB_WDATA[8*b +: 8];
                    end
                end else begin
                    bus.APB_READY  = 1'b0;
                    bus.APB_SLVERR = 1'b0;
                end
                en_cnt++;
            end else begin
                bus.APB_READY  = 1'b0;
                bus.APB_SLVERR = 1'b0;
                en_cnt         = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transfer tasks (all entered and left at a negedge)
    // ------------------------------------------------------------------
    task automatic start_cmd(input vec_t v, output int waited);
        exp_t e;
        int   n;
        e.rdata = v.e_rdata;
        e.err   = v.e_err;
        e.to    = v.e_to;
        sb.push_back(e);
        slv_delay     = v.dly;
        slv_err       = v.serr;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_strb  = v.strb;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept_bound", 64'(n < 50), 64'(1));
        waited = n;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("after_accept_sel_en_rdy", 64'({bus.APB_SEL, bus.APB_ENABLE, bus.cmd_ready}), 64'(3'b100));
    endtask

    task automatic wait_rsp(input vec_t v);
        int   setup_n = 0;
        int   acc_n   = 0;
        int   n       = 0;
        logic ok      = 1'b1;
        exp_t e;
        while (bus.rsp_valid !== 1'b1 && n < 300) begin
            if (bus.APB_SEL === 1'b1 && bus.APB_ENABLE === 1'b0) begin
                setup_n++;
                if (acc_n != 0) ok = 1'b0;
            end else if (bus.APB_SEL === 1'b1 && bus.APB_ENABLE === 1'b1) begin
                acc_n++;
            end else begin
                ok = 1'b0;
            end
            if (bus.APB_ADDR !== v.e_addr || bus.APB_STRB !== v.e_strb ||
                bus.APB_WRITE !== v.wr || bus.cmd_ready !== 1'b0) ok = 1'b0;
            if (v.wr && bus.APB_WDATA !== v.wdata) ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check("rsp_valid_bound", 64'(n < 300), 64'(1));
        check("setup_cycles", 64'(setup_n), 64'(1));
        check("access_cycles", 64'(acc_n), 64'(v.e_acc));
        check("apb_fields_stable", 64'(ok), 64'(1));
        check("sel_en_drop_at_rsp", 64'({bus.APB_SEL, bus.APB_ENABLE}), 64'(2'b00));
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 64'(0), 64'(1));
        end else begin
            e = sb.pop_front();
            check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
            check("rsp_err_timeout", 64'({bus.rsp_err, bus.rsp_timeout}), 64'({e.err, e.to}));
        end
    endtask

    task automatic finish_rsp(input int bp);
        logic [33:0] snap;
        logic        ok = 1'b1;
        snap = {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout};
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 ||
                {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== snap) ok = 1'b0;
        end
        check("rsp_hold_stable", 64'(ok), 64'(1));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_release_vld_rdy", 64'({bus.rsp_valid, bus.cmd_ready}), 64'(2'b01));
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    vec_t vecs[12];

    initial begin
        vec_t va, vb, vr;
        int   waited;
        int   n;
        exp_t drop;

        //         wr    addr          wdata         strb  dly serr bp  e_addr        e_strb e_rdata       err   to   acc
        vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 1,   1'b0, 0, 32'h0000_0008, 4'hF, 32'h0,         1'b0, 1'b0, 2};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'hF, 1,   1'b0, 0, 32'h0000_0008, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2};
        vecs[2]  = '{1'b1, 32'h0000_000B, 32'h1234_5678, 4'h3, 0,   1'b0, 0, 32'h0000_0008, 4'h3, 32'h0,         1'b0, 1'b0, 1};
        vecs[3]  = '{1'b0, 32'h0000_000A, 32'h0,         4'h0, 3,   1'b0, 2, 32'h0000_0008, 4'h0, 32'hDEAD_5678, 1'b0, 1'b0, 4};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0,   1'b1, 0, 32'h0000_0010, 4'h0, 32'h0,         1'b1, 1'b0, 1};
        vecs[5]  = '{1'b1, 32'h0000_0014, 32'h1111_1111, 4'hF, 2,   1'b1, 0, 32'h0000_0014, 4'hF, 32'h0,         1'b1, 1'b0, 3};
        vecs[6]  = '{1'b0, 32'h0000_001C, 32'h0,         4'h0, 255, 1'b0, 1, 32'h0000_001C, 4'h0, 32'h0,         1'b1, 1'b1, 16};
        vecs[7]  = '{1'b0, 32'h0000_001C, 32'h0,         4'h0, 15,  1'b0, 0, 32'h0000_001C, 4'h0, 32'hA5A5_0007, 1'b0, 1'b0, 16};
        vecs[8]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 14,  1'b0, 0, 32'h0000_0004, 4'h0, 32'hA5A5_0001, 1'b0, 1'b0, 15};
        vecs[9]  = '{1'b1, 32'h0000_003C, 32'hCAFE_F00D, 4'hC, 2,   1'b0, 0, 32'h0000_003C, 4'hC, 32'h0,         1'b0, 1'b0, 3};
        vecs[10] = '{1'b0, 32'h0000_003F, 32'h0,         4'h0, 1,   1'b0, 3, 32'h0000_003C, 4'h0, 32'hCAFE_000F, 1'b0, 1'b0, 2};
        vecs[11] = '{1'b0, 32'hFFFF_FFF7, 32'h0,         4'h0, 1,   1'b0, 0, 32'hFFFF_FFF4, 4'h0, 32'hA5A5_000D, 1'b0, 1'b0, 2};

        rst_n         = 1'b0;
        slv_delay     = 0;
        slv_err       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset_ctrl", 64'({bus.cmd_ready, bus.rsp_valid, bus.APB_SEL, bus.APB_ENABLE, bus.APB_WRITE}), 64'(5'b10000));
        check("reset_addr_wdata", {bus.APB_ADDR, bus.APB_WDATA}, 64'(0));
        check("reset_strb_prot", 64'({bus.APB_STRB, bus.APB_PROT}), 64'({4'h0, c_PROT}));
        check("reset_rsp_fields", 64'({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            start_cmd(vecs[i], waited);
            wait_rsp(vecs[i]);
            finish_rsp(vecs[i].bp);
        end

        // Response backpressure with a second command pending
        va = '{1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 4'hF, 1, 1'b0, 0, 32'h0000_0020, 4'hF, 32'h0,         1'b0, 1'b0, 2};
        vb = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 1, 1'b0, 0, 32'h0000_0020, 4'h0, 32'h0BAD_CAFE, 1'b0, 1'b0, 2};
        start_cmd(va, waited);
        wait_rsp(va);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = vb.wr;
        bus.cmd_addr  = vb.addr;
        bus.cmd_wdata = vb.wdata;
        bus.cmd_strb  = vb.strb;
        finish_rsp(5);
        start_cmd(vb, waited);
        check("bp_second_accept_wait", 64'(waited), 64'(0));
        wait_rsp(vb);
        finish_rsp(0);

        // Reset asserted during ACCESS
        vr = '{1'b0, 32'h0000_0020, 32'h0, 4'h0, 255, 1'b0, 0, 32'h0000_0020, 4'h0, 32'h0, 1'b0, 1'b0, 0};
        start_cmd(vr, waited);
        n = 0;
        while (bus.APB_ENABLE !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("enable_seen_before_reset", 64'(bus.APB_ENABLE), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", 64'({bus.APB_SEL, bus.APB_ENABLE, bus.APB_WRITE, bus.rsp_valid, bus.cmd_ready}), 64'(5'b00001));
        check("async_reset_addr_strb", 64'({bus.APB_ADDR, bus.APB_STRB}), 64'(0));
        if (sb.size() != 0) drop = sb.pop_front();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_no_rsp", 64'({bus.rsp_valid, bus.cmd_ready, bus.APB_SEL}), 64'(3'b010));

        // A following read completes normally
        start_cmd(vb, waited);
        wait_rsp(vb);
        finish_rsp(0);

        check("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
